// File: rtl/afe_cfg_pkg.sv
// Shared types, constants and frame formatting for the AFE register-programming sequencer.
package afe_cfg_pkg;

    localparam int FRAME_W        = 16;
    localparam int REG_W          = 9;
    localparam int NUM_WORDS      = 12;
    localparam int WORDS_PER_CHIP = 6;

    localparam logic [2:0] ADDR_CONFIG  = 3'd0;
    localparam logic [2:0] ADDR_MUX     = 3'd1;
    localparam logic [2:0] ADDR_GAINA   = 3'd2;
    localparam logic [2:0] ADDR_GAINB   = 3'd3;
    localparam logic [2:0] ADDR_OFFSETA = 3'd4;
    localparam logic [2:0] ADDR_OFFSETB = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FRAME,
        GAP,
        FIN
    } state_e;

    // Write frame: R/W bit (0 = write), 3-bit address, 3 reserved zeros, 9-bit data.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [2:0]       addr,
                                                       input logic [REG_W-1:0] data);
        return {1'b0, addr, 3'b000, data};
    endfunction

endpackage

// File: rtl/afe_sif_tx.sv
// One-word serial transmitter: divides the system clock into SCLK and shifts a 16-bit frame out MSB first.
module afe_sif_tx
    import afe_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] word_i,
    input  logic               chip2_i,
    output logic               sclk_o,
    output logic               sdata_o,
    output logic               sload1_n_o,
    output logic               sload2_n_o,
    output logic               word_done_o
);

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic               active_q, active_d;
    logic               tail_q, tail_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         bit_q, bit_d;
    logic               sclk_q, sclk_d;
    logic               sdata_q, sdata_d;
    logic               sload1_n_q, sload1_n_d;
    logic               sload2_n_q, sload2_n_d;
    logic [FRAME_W-2:0] shreg_q;
    logic               half_tick;
    logic               shift;

    assign half_tick = active_q && (div_q == DIV_LAST);
    assign shift     = half_tick && sclk_q && !tail_q;

    // After the 16th falling edge the strobe is held low one more half-period (tail).
    assign word_done_o = half_tick && tail_q;

    always_comb begin
        active_d   = active_q;
        tail_d     = tail_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sclk_d     = sclk_q;
        sdata_d    = sdata_q;
        sload1_n_d = sload1_n_q;
        sload2_n_d = sload2_n_q;
        if (start_i) begin
            active_d   = 1'b1;
            tail_d     = 1'b0;
            div_d      = '0;
            bit_d      = 4'd15;
            sclk_d     = 1'b0;
            sdata_d    = word_i[FRAME_W-1];
            sload1_n_d = chip2_i;
            sload2_n_d = !chip2_i;
        end else if (active_q) begin
            div_d = half_tick ? '0 : div_q + DIV_W'(1);
            if (half_tick) begin
                if (tail_q) begin
                    active_d   = 1'b0;
                    tail_d     = 1'b0;
                    sdata_d    = 1'b0;
                    sload1_n_d = 1'b1;
                    sload2_n_d = 1'b1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    // Data moves on the falling edge so the AFE samples a settled bit on the rise.
                    sclk_d  = 1'b0;
                    sdata_d = shreg_q[FRAME_W-2];
                    if (bit_q == 4'd0) begin
                        tail_d = 1'b1;
                    end else begin
                        bit_d = bit_q - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q   <= 1'b0;
            tail_q     <= 1'b0;
            div_q      <= '0;
            bit_q      <= 4'd0;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            sload1_n_q <= 1'b1;
            sload2_n_q <= 1'b1;
        end else begin
            active_q   <= active_d;
            tail_q     <= tail_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            sload1_n_q <= sload1_n_d;
            sload2_n_q <= sload2_n_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_i) begin
            shreg_q <= word_i[FRAME_W-2:0];
        end else if (shift) begin
            shreg_q <= {shreg_q[FRAME_W-3:0], 1'b0};
        end
    end

    assign sclk_o     = sclk_q;
    assign sdata_o    = sdata_q;
    assign sload1_n_o = sload1_n_q;
    assign sload2_n_o = sload2_n_q;

endmodule

// File: rtl/afe_cfg_seq.sv
// AFE configuration sequencer: snapshots twelve register values on a write request and
// programs both AFE chips over the shared serial interface, then flags the config valid.
module afe_cfg_seq
    import afe_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             adc_clk,
    input  logic             rest,
    input  logic             wrpara_eable,
    input  logic [REG_W-1:0] cmd_config1,
    input  logic [REG_W-1:0] cmd_mux1,
    input  logic [REG_W-1:0] cmd_gaina1,
    input  logic [REG_W-1:0] cmd_gainb1,
    input  logic [REG_W-1:0] cmd_offseta1,
    input  logic [REG_W-1:0] cmd_offsetb1,
    input  logic [REG_W-1:0] cmd_config2,
    input  logic [REG_W-1:0] cmd_mux2,
    input  logic [REG_W-1:0] cmd_gaina2,
    input  logic [REG_W-1:0] cmd_gainb2,
    input  logic [REG_W-1:0] cmd_offseta2,
    input  logic [REG_W-1:0] cmd_offsetb2,
    output logic             afe_sclk,
    output logic             afe_sdata,
    output logic             afe_sload1_n,
    output logic             afe_sload2_n,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_valid
);

    localparam int               GAP_W    = $clog2(2 * CLK_DIV + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 1);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_WORDS - 1);

    state_e             state_q, state_d;
    logic               wr_q;
    logic               pend_q, pend_d;
    logic [3:0]         idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               busy_q, done_q, valid_q;
    logic               trig;
    logic               start;
    logic               word_done;
    logic               chip2;
    logic [2:0]         slot;
    logic [2:0]         addr;
    logic [FRAME_W-1:0] word;
    logic [REG_W-1:0]   cmd_w  [NUM_WORDS];
    logic [REG_W-1:0]   snap_q [NUM_WORDS];

    assign cmd_w = '{cmd_config1, cmd_mux1, cmd_gaina1, cmd_gainb1, cmd_offseta1, cmd_offsetb1,
                     cmd_config2, cmd_mux2, cmd_gaina2, cmd_gainb2, cmd_offseta2, cmd_offsetb2};

    assign trig = wrpara_eable && !wr_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        gap_d   = '0;
        start   = 1'b0;
        if (trig && (state_q inside {LOAD, FRAME, GAP})) begin
            pend_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                idx_d   = 4'd0;
                start   = 1'b1;
                state_d = FRAME;
            end
            FRAME: begin
                if (word_done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (idx_q < IDX_LAST) begin
                        idx_d   = idx_q + 4'd1;
                        start   = 1'b1;
                        state_d = FRAME;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                // A request arriving in FIN itself is treated like a pending one.
                pend_d  = 1'b0;
                state_d = (pend_q || trig) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word selection uses the index of the frame about to start.
    always_comb begin
        chip2 = (idx_d >= 4'(WORDS_PER_CHIP));
        slot  = 3'(chip2 ? idx_d - 4'(WORDS_PER_CHIP) : idx_d);
        unique case (slot)
            3'd0:    addr = ADDR_CONFIG;
            3'd1:    addr = ADDR_MUX;
            3'd2:    addr = ADDR_GAINA;
            3'd3:    addr = ADDR_GAINB;
            3'd4:    addr = ADDR_OFFSETA;
            3'd5:    addr = ADDR_OFFSETB;
            default: addr = ADDR_CONFIG;
        endcase
        word = build_frame(addr, snap_q[idx_d]);
    end

    always_ff @(posedge adc_clk or posedge rest) begin
        if (rest) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            pend_q  <= 1'b0;
            idx_q   <= 4'd0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wrpara_eable;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            busy_q  <= (state_d inside {LOAD, FRAME, GAP});
            done_q  <= (state_d == FIN);
            valid_q <= (state_d == FIN) || (valid_q && (state_d != LOAD));
        end
    end

    always_ff @(posedge adc_clk) begin
        if (state_d == LOAD) begin
            snap_q <= cmd_w;
        end
    end

    afe_sif_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk_i       (adc_clk),
        .rst_i       (rest),
        .start_i     (start),
        .word_i      (word),
        .chip2_i     (chip2),
        .sclk_o      (afe_sclk),
        .sdata_o     (afe_sdata),
        .sload1_n_o  (afe_sload1_n),
        .sload2_n_o  (afe_sload2_n),
        .word_done_o (word_done)
    );

    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_valid = valid_q;

endmodule

// File: tb/tb_afe_cfg_seq.sv
// Directed bench for afe_cfg_seq: two instances (CLK_DIV=4 and CLK_DIV=2) share the same stimulus.
module tb_afe_cfg_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic [8:0] c_config1, c_mux1, c_gaina1, c_gainb1, c_offseta1, c_offsetb1;
    logic [8:0] c_config2, c_mux2, c_gaina2, c_gainb2, c_offseta2, c_offsetb2;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int CD = (g == 0) ? 4 : 2;
        logic sclk, sdata, s1, s2, busy, done, valid;
        int viol = 0, fcnt = 0, rises = 0, dcnt = 0, bits = 0, edge_t = 0, srise_t = 0;
        logic [15:0] cur = '0;
        logic [15:0] fw [32];
        logic [1:0]  fchip [32];
        int   done_t [4];
        int   fc_at [4];
        int   rise_at [4];
        logic busy_after [4];
        logic p_sclk = 1'b0, p_d = 1'b0, p_s1 = 1'b1, p_s2 = 1'b1, p_done = 1'b0;

        afe_cfg_seq #(.CLK_DIV(CD)) u_dut (
            .adc_clk      (clk),
            .rest         (rst),
            .wrpara_eable (wr),
            .cmd_config1  (c_config1),
            .cmd_mux1     (c_mux1),
            .cmd_gaina1   (c_gaina1),
            .cmd_gainb1   (c_gainb1),
            .cmd_offseta1 (c_offseta1),
            .cmd_offsetb1 (c_offsetb1),
            .cmd_config2  (c_config2),
            .cmd_mux2     (c_mux2),
            .cmd_gaina2   (c_gaina2),
            .cmd_gainb2   (c_gainb2),
            .cmd_offseta2 (c_offseta2),
            .cmd_offsetb2 (c_offsetb2),
            .afe_sclk     (sclk),
            .afe_sdata    (sdata),
            .afe_sload1_n (s1),
            .afe_sload2_n (s2),
            .cfg_busy     (busy),
            .cfg_done     (done),
            .cfg_valid    (valid)
        );

        // Frame capture and protocol timing watch, sampled on the falling clock edge.
        always @(negedge clk) begin
            if (!rst) begin
                if (!s1 && !s2) viol++;
                if (p_sclk && sclk && (sdata != p_d)) viol++;
                if (s1 && s2 && (sdata || sclk)) viol++;
                if (p_s1 && p_s2 && !(s1 && s2)) begin
                    if (((fcnt % 12) != 0) && ((cyc - srise_t) != 2 * CD)) viol++;
                    edge_t = cyc;
                    bits   = 0;
                    cur    = '0;
                end else if (!(p_s1 && p_s2) && !(s1 && s2) && (sclk != p_sclk)) begin
                    if ((cyc - edge_t) != CD) viol++;
                    edge_t = cyc;
                    if (sclk) begin
                        bits++;
                        rises++;
                        cur = {cur[14:0], sdata};
                    end
                end else if (!(p_s1 && p_s2) && s1 && s2) begin
                    if (((cyc - edge_t) != CD) || (bits != 16)) viol++;
                    if (fcnt < 32) begin
                        fw[fcnt]    = cur;
                        fchip[fcnt] = p_s1 ? 2'd2 : 2'd1;
                    end
                    fcnt++;
                    srise_t = cyc;
                end
                if (p_done && done) viol++;
                if (done && busy) viol++;
                if (p_done && (dcnt >= 1) && (dcnt <= 4)) busy_after[dcnt-1] = busy;
                if (done) begin
                    if (dcnt < 4) begin
                        done_t[dcnt]  = cyc;
                        fc_at[dcnt]   = fcnt;
                        rise_at[dcnt] = rises;
                    end
                    dcnt++;
                end
            end
            p_sclk = sclk;
            p_d    = sdata;
            p_s1   = s1;
            p_s2   = s2;
            p_done = done;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [15:0] exp_fw [24] = '{
        16'h00C8, 16'h1055, 16'h2100, 16'h30AA, 16'h4010, 16'h51F0,
        16'h0123, 16'h103C, 16'h20F0, 16'h31FF, 16'h4002, 16'h5180,
        16'h01A5, 16'h1055, 16'h2100, 16'h30AA, 16'h4020, 16'h51F0,
        16'h0123, 16'h103C, 16'h20F0, 16'h30F5, 16'h4002, 16'h5180};

    int e;
    int t;
    int nr0, nr1;
    logic ps0, ps1;

    initial begin
        c_config1 = 9'h0C8; c_mux1 = 9'h055; c_gaina1 = 9'h100;
        c_gainb1 = 9'h0AA; c_offseta1 = 9'h010; c_offsetb1 = 9'h1F0;
        c_config2 = 9'h123; c_mux2 = 9'h03C; c_gaina2 = 9'h0F0;
        c_gainb2 = 9'h1FF; c_offseta2 = 9'h002; c_offsetb2 = 9'h180;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_d4", 32'({g_u[0].sclk, g_u[0].sdata, g_u[0].s1, g_u[0].s2,
                                g_u[0].busy, g_u[0].done, g_u[0].valid}), 32'h18);
        check_eq("rst_d2", 32'({g_u[1].sclk, g_u[1].sdata, g_u[1].s1, g_u[1].s2,
                                g_u[1].busy, g_u[1].done, g_u[1].valid}), 32'h18);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("idle_d4", 32'({g_u[0].sclk, g_u[0].s1, g_u[0].s2, g_u[0].busy}), 32'h6);

        // Sequence 1 with a pending request raised during word 5 of the CLK_DIV=4 instance.
        e  = cyc;
        wr = 1'b1;
        wait_to(e + 1);
        check_eq("load_busy_d4", 32'(g_u[0].busy), 32'd1);
        wait_to(e + 302);
        check_eq("mid_busy_d4", 32'(g_u[0].busy), 32'd1);
        check_eq("mid_valid_d4", 32'(g_u[0].valid), 32'd0);
        c_offseta1 = 9'h020;
        wait_to(e + 702);  wr = 1'b0;
        wait_to(e + 714);  wr = 1'b1;
        wait_to(e + 717);  wr = 1'b0;
        wait_to(e + 732);  wr = 1'b1;
        wait_to(e + 735);  wr = 1'b0;
        wait_to(e + 802);
        c_config1 = 9'h1A5;
        c_gainb2  = 9'h0F5;

        while (!((g_u[0].dcnt >= 2) && (g_u[1].dcnt >= 2)) && (cyc < e + 4000)) begin
            @(posedge clk);
            #1;
        end
        check_eq("seq_timeout", 32'(cyc < e + 4000), 32'd1);
        wait_to(cyc + 100);

        check_eq("dcnt_d4", 32'(g_u[0].dcnt), 32'd2);
        check_eq("dcnt_d2", 32'(g_u[1].dcnt), 32'd2);
        check_eq("done0_t_d4", 32'(g_u[0].done_t[0] - e), 32'd1682);
        check_eq("done1_t_d4", 32'(g_u[0].done_t[1] - e), 32'd3364);
        check_eq("done0_t_d2", 32'(g_u[1].done_t[0] - e), 32'd842);
        check_eq("done1_t_d2", 32'(g_u[1].done_t[1] - e), 32'd1684);
        check_eq("frames0_d4", 32'(g_u[0].fc_at[0]), 32'd12);
        check_eq("frames1_d4", 32'(g_u[0].fc_at[1]), 32'd24);
        check_eq("frames0_d2", 32'(g_u[1].fc_at[0]), 32'd12);
        check_eq("frames1_d2", 32'(g_u[1].fc_at[1]), 32'd24);
        check_eq("rises0_d4", 32'(g_u[0].rise_at[0]), 32'd192);
        check_eq("rises1_d4", 32'(g_u[0].rise_at[1]), 32'd384);
        check_eq("rises0_d2", 32'(g_u[1].rise_at[0]), 32'd192);
        check_eq("rises1_d2", 32'(g_u[1].rise_at[1]), 32'd384);
        check_eq("rebusy_d4", 32'(g_u[0].busy_after[0]), 32'd1);
        check_eq("idle_after_d4", 32'(g_u[0].busy_after[1]), 32'd0);
        check_eq("rebusy_d2", 32'(g_u[1].busy_after[0]), 32'd1);
        check_eq("timing_d4", 32'(g_u[0].viol), 32'd0);
        check_eq("timing_d2", 32'(g_u[1].viol), 32'd0);
        check_eq("end_state_d4", 32'({g_u[0].busy, g_u[0].valid}), 32'h1);
        check_eq("end_state_d2", 32'({g_u[1].busy, g_u[1].valid}), 32'h1);
        for (int i = 0; i < 24; i++) begin
            check_eq($sformatf("frame%0d_d4", i), 32'(g_u[0].fw[i]), 32'(exp_fw[i]));
            check_eq($sformatf("frame%0d_d2", i), 32'(g_u[1].fw[i]), 32'(exp_fw[i]));
            check_eq($sformatf("chip%0d_d4", i), 32'(g_u[0].fchip[i]), ((i % 12) < 6) ? 32'd1 : 32'd2);
        end

        // Reset in the middle of word 0 of a third sequence.
        t  = cyc;
        wr = 1'b1;
        wait_to(t + 50);
        check_eq("pre_rst_strobe_d4", 32'({g_u[0].s1, g_u[0].busy}), 32'h1);
        check_eq("pre_rst_strobe_d2", 32'({g_u[1].s1, g_u[1].busy}), 32'h1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_d4", 32'({g_u[0].sclk, g_u[0].sdata, g_u[0].s1, g_u[0].s2,
                                      g_u[0].busy, g_u[0].done, g_u[0].valid}), 32'h18);
        check_eq("async_rst_d2", 32'({g_u[1].sclk, g_u[1].sdata, g_u[1].s1, g_u[1].s2,
                                      g_u[1].busy, g_u[1].done, g_u[1].valid}), 32'h18);
        wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nr0 = 0;
        nr1 = 0;
        ps0 = g_u[0].sclk;
        ps1 = g_u[1].sclk;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (g_u[0].sclk && !ps0) nr0++;
            if (g_u[1].sclk && !ps1) nr1++;
            ps0 = g_u[0].sclk;
            ps1 = g_u[1].sclk;
        end
        check_eq("post_rst_sclk_d4", 32'(nr0), 32'd0);
        check_eq("post_rst_sclk_d2", 32'(nr1), 32'd0);
        check_eq("post_rst_busy", 32'({g_u[0].busy, g_u[1].busy}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/afe_cfg_seq.md
# afe_cfg_seq

Serial register-programming sequencer for the two analog front-end (AFE) chips feeding the CIS ADC path. On a write request it snapshots the twelve 9-bit AFE register values (config, mux, gain A/B, offset A/B per chip) and shifts them out as 16-bit write frames over a shared 3-wire serial interface. Each chip has its own load strobe. The block sits beside the ADC capture logic and reports when the AFEs hold a valid configuration, so sampling can be gated on it.

## Interface
- CLK_DIV, 4, adc_clk cycles per SCLK half-period; legal range 2..255
- adc_clk  in  1  system clock; all logic on its rising edge
- rest  in  1  asynchronous, active-high reset
- wrpara_eable  in  1  write request; the rising edge is the trigger
- cmd_config1, cmd_mux1, cmd_gaina1, cmd_gainb1, cmd_offseta1, cmd_offsetb1  in  9 each  chip-1 register values
- cmd_config2, cmd_mux2, cmd_gaina2, cmd_gainb2, cmd_offseta2, cmd_offsetb2  in  9 each  chip-2 register values
- afe_sclk  out  1  serial clock; idles low
- afe_sdata  out  1  serial data, MSB first
- afe_sload1_n  out  1  chip-1 frame strobe, active low
- afe_sload2_n  out  1  chip-2 frame strobe, active low
- cfg_busy  out  1  sequence in progress
- cfg_done  out  1  one-cycle pulse when a sequence completes
- cfg_valid  out  1  the AFEs hold the last requested configuration

## Operation
- Reset values: afe_sclk=0, afe_sdata=0, afe_sload1_n=1, afe_sload2_n=1, cfg_busy=0, cfg_done=0, cfg_valid=0. Pending flag and edge register are cleared.
- Trigger: wrpara_eable is registered once and its rising edge is detected.
  - An edge in IDLE starts a sequence.
  - An edge while busy sets a single pending flag. Further edges while busy are absorbed into that flag.
- Snapshot: all twelve inputs are latched in the cycle IDLE→LOAD. Input changes after that cycle do not affect the sequence in progress.
- Word order: index 0..11 = chip1 {config, mux, gaina, gainb, offseta, offsetb}, then chip2 in the same order. Register addresses within each chip are 0..5 in that order.
- Frame (16 bits, sent bit15 first): bit15=0 (write), bits14:12=address, bits11:9=000, bits8:0=data.
- Strobe select: indices 0..5 drive afe_sload1_n; indices 6..11 drive afe_sload2_n. Only one strobe is ever low.
- FSM states:
  - IDLE: on edge → LOAD.
  - LOAD: snapshot; index=0; set cfg_busy=1 and cfg_valid=0 → FRAME.
  - FRAME: drive one word (below) → GAP.
  - GAP: strobe high for 2·CLK_DIV cycles. If index<11, increment index → FRAME; else → FIN.
  - FIN: cfg_done=1, cfg_busy=0, cfg_valid=1 for that cycle onward. If pending, clear it → LOAD next cycle; else → IDLE.
- Counters:
  - divider is $clog2(CLK_DIV+1) bits wide;
  - bit counter is 4 bits and counts 15→0 without wrap;
  - index is 4 bits and never exceeds 11.
- Reset mid-sequence: all outputs return to reset values immediately. The partial frame is abandoned and the pending flag is lost.

## Timing
- Start latency: edge on wrpara_eable at cycle e. The registered edge is seen at e+1, LOAD at e+1, FRAME starts at t0=e+2.
- Per word, with t0 = the first FRAME cycle:
  - the strobe goes low and afe_sdata=bit15 at t0;
  - afe_sclk rises at t0+k·2·CLK_DIV+CLK_DIV and falls at t0+(k+1)·2·CLK_DIV, for k=0..15;
  - afe_sdata updates to the next bit in the same cycle as each falling edge, so the AFE samples on the rising edge;
  - the strobe rises at t0+33·CLK_DIV, one half-period after the 16th falling edge;
  - afe_sdata returns to 0 while the strobe is high.
- Word period = 35·CLK_DIV cycles. A full sequence takes 420·CLK_DIV cycles from the first t0 to FIN (1680 cycles at CLK_DIV=4).
- cfg_done is high exactly one cycle. cfg_busy falls in that same cycle. With pending set, cfg_busy goes back high in the next cycle.

## Structure
- The package afe_cfg_pkg holds:
  - the state enum (IDLE, LOAD, FRAME, GAP, FIN);
  - the address constants ADDR_CONFIG=0 … ADDR_OFFSETB=5;
  - FRAME_W=16 and REG_W=9;
  - a frame-build function (addr, data) → 16-bit word.
- One sub-module, afe_sif_tx: a one-word shifter plus divider.
  - Inputs: start, word, chip select.
  - Outputs: sclk, sdata, both strobes, word_done.
  - The top module keeps the FSM, snapshot, index and pending logic.

## Test plan
- Reset: assert rest mid-run → all outputs at reset values in the same cycle; no SCLK edges for 100 cycles after release.
- Single sequence, CLK_DIV=4, cmd_config1=9'h0C8, cmd_gainb2=9'h1FF:
  - word 0 is 16'h00C8 on afe_sload1_n;
  - word 9 is 16'h31FF on afe_sload2_n;
  - exactly 12 frames and 192 SCLK rising edges;
  - cfg_done at e+2+1680.
- Snapshot: change cmd_offseta1 from 9'h010 to 9'h020 during word 2 → word 4 still carries 16'h4010.
- Request while busy: two edges during word 5 → exactly one additional sequence starts the cycle after FIN and uses the inputs present at its LOAD. cfg_done pulses twice.
- Timing checks:
  - sdata is stable while sclk is high;
  - the strobe is low CLK_DIV cycles before the first rise and stays low CLK_DIV cycles after the last fall;
  - both strobes are never low together;
  - the gap between frames is 2·CLK_DIV cycles.
- CLK_DIV=2 minimum: same frames as the single-sequence case; sequence length 840 cycles.
